screen_flow_controller: RTL
===========================

Name: screen_flow_controller

Overview:
Top-level game-flow stage directly downstream of the main play screen. It consumes the main screen's life/score outputs and generates that screen's start pulse. It sequences START -> PLAY -> END -> START and keeps a session high score. It selects which screen RGB stream reaches the VGA output, with one registered cycle.

Parameters:
WIN_SCORE, 4'd10, score at or above which the game ends as a win
HOLDOFF_FRAMES, 120, frames in END during which the start key is ignored
BLINK_FRAMES, 30, frames per half-period of the END-screen blink

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per video frame
key5IsPressed  in  1  start/continue key level (debounced upstream)
life  in  4  remaining lives from main screen
score  in  4  current score from main screen
RGB_screen_start  in  8  start-screen pixel
RGB_screen_main  in  8  main-screen pixel
RGB_screen_end  in  8  end-screen pixel
start  out  1  one-cycle pulse that (re)starts the main screen
RGB_out  out  8  selected pixel, registered
screen_state  out  2  0=START, 1=PLAY, 2=END_LOSE, 3=END_WIN
high_score  out  4  best final score since reset
blink  out  1  END-screen blink phase

Behaviour:
- Reset (synchronous, active-high): state=START; start=0; RGB_out=0; high_score=0; blink=0; all counters=0; armed=0; key_prev=1. Because key_prev resets to 1, a key held through reset does not trigger.
- Key edge: key_rise = key5IsPressed & ~key_prev. key_prev is registered every cycle.
- START: RGB source = RGB_screen_start. On key_rise -> PLAY, with start=1 for exactly that one cycle. Clear armed.
- PLAY: RGB source = RGB_screen_main.
  - armed sets on the first cycle life!=0 is sampled in PLAY. This masks the stale life=0 left before the main screen reloads.
  - win = (score >= WIN_SCORE), unsigned 4-bit compare, evaluated every cycle.
  - lose = armed & (life == 0).
  - win and lose on the same cycle -> END_WIN (win has priority).
  - key_rise in PLAY is ignored; pause is handled inside the main screen.
- Entry to END_WIN or END_LOSE, on the transition cycle:
  - if score > high_score, latch high_score <= score;
  - frame_cnt = 0, blink_cnt = 0, blink = 1.
- END_* states:
  - Each startOfFrame increments frame_cnt, saturating at HOLDOFF_FRAMES, and increments blink_cnt.
  - When blink_cnt reaches BLINK_FRAMES-1 on a startOfFrame, blink_cnt = 0 and blink toggles.
  - RGB source = RGB_screen_end when blink=1, else RGB_screen_main, showing the frozen final play field.
  - key_rise with frame_cnt < HOLDOFF_FRAMES is ignored.
  - key_rise with frame_cnt == HOLDOFF_FRAMES -> START.
- Outside END, blink is held at 0.
- RGB_out <= selected source each cycle. Latency is exactly 1 clk; the select takes effect on the cycle after the state change.
- start is never asserted outside the START->PLAY transition.
- start is never asserted for two consecutive cycles.
- reset asserted mid-game returns to START on the next edge. high_score is cleared.
- score/life are sampled as unsigned. No arithmetic beyond compare and counter increment.
- Counter widths: frame_cnt and blink_cnt each at least $clog2 of their parameter + 1. Neither counter may wrap.

Test Plan:
- Reset with key5 held high, then keep it held 10 cycles -> state=0, start never pulses. Release then press -> start=1 for exactly 1 cycle, screen_state=1 next cycle.
- PLAY with life=0 for 3 cycles after start, then life=3, then life=0 -> no END during the first 0 window; END_LOSE (2) on the cycle after life returns to 0.
- PLAY with life=3, score goes 9 -> 10 -> screen_state=3; high_score=10. A later game ending at score 4 leaves high_score=10.
- Same-cycle score=10 and life=0 with armed=1 -> screen_state=3, not 2.
- In END, press key at frame 50 -> stays in END. After 120 startOfFrame pulses, press -> START; no start pulse until a further key_rise.
- Blink and mux in END with BLINK_FRAMES=30 -> blink toggles every 30 frames. RGB_out equals RGB_screen_end when blink=1 and RGB_screen_main otherwise, each delayed 1 clk. In START, RGB_out tracks RGB_screen_start with 1-cycle latency.

Source files
------------

// File: rtl/screen_flow_controller.sv
// Game-flow sequencer START -> PLAY -> END -> START. It keeps the session high score
// and drives a registered RGB select between the start, main and end screens.
module screen_flow_controller #(
  parameter logic [3:0] WIN_SCORE      = 4'd10,
  parameter int         HOLDOFF_FRAMES = 120,
  parameter int         BLINK_FRAMES   = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       key5IsPressed,
  input  logic [3:0] life,
  input  logic [3:0] score,
  input  logic [7:0] RGB_screen_start,
  input  logic [7:0] RGB_screen_main,
  input  logic [7:0] RGB_screen_end,
  output logic       start,
  output logic [7:0] RGB_out,
  output logic [1:0] screen_state,
  output logic [3:0] high_score,
  output logic       blink
);

  localparam int FW = $clog2(HOLDOFF_FRAMES) + 1;
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [FW-1:0] HOLDOFF_MAX = FW'(HOLDOFF_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    START    = 2'd0,
    PLAY     = 2'd1,
    END_LOSE = 2'd2,
    END_WIN  = 2'd3
  } state_t;

  state_t        state, stateNext;
  logic          keyPrev, armed;
  logic          keyRise, inEnd, win, lose, enterEnd;
  logic [FW-1:0] frameCnt;
  logic [BW-1:0] blinkCnt;
  logic [7:0]    rgbSel;

  always_comb begin
    keyRise   = key5IsPressed & ~keyPrev;
    inEnd     = (state == END_LOSE) || (state == END_WIN);
    win       = (score >= WIN_SCORE);
    lose      = armed & (life == 4'd0);
    enterEnd  = 1'b0;
    stateNext = state;
    unique case (state)
      START: if (keyRise) stateNext = PLAY;
      PLAY: begin
        // win outranks lose when both land on the same cycle
        if (win) begin
          stateNext = END_WIN;
          enterEnd  = 1'b1;
        end else if (lose) begin
          stateNext = END_LOSE;
          enterEnd  = 1'b1;
        end
      end
      END_LOSE, END_WIN:
        if (keyRise && (frameCnt == HOLDOFF_MAX)) stateNext = START;
      default: stateNext = START;
    endcase
  end

  always_comb begin
    rgbSel = RGB_screen_start;
    unique case (state)
      START:             rgbSel = RGB_screen_start;
      PLAY:              rgbSel = RGB_screen_main;
      END_LOSE, END_WIN: rgbSel = blink ? RGB_screen_end : RGB_screen_main;
      default:           rgbSel = RGB_screen_start;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= START;
      start      <= 1'b0;
      RGB_out    <= 8'd0;
      high_score <= 4'd0;
      blink      <= 1'b0;
      frameCnt   <= '0;
      blinkCnt   <= '0;
      armed      <= 1'b0;
      keyPrev    <= 1'b1;
    end else begin
      state   <= stateNext;
      keyPrev <= key5IsPressed;
      start   <= (state == START) && keyRise;
      RGB_out <= rgbSel;

      // armed masks the stale life=0 left over until the main screen reloads
      if (state == START)
        armed <= 1'b0;
      else if ((state == PLAY) && (life != 4'd0))
        armed <= 1'b1;

      if (enterEnd) begin
        if (score > high_score) high_score <= score;
        frameCnt <= '0;
        blinkCnt <= '0;
        blink    <= 1'b1;
      end else if (inEnd && (stateNext != START)) begin
        if (startOfFrame) begin
          if (frameCnt != HOLDOFF_MAX) frameCnt <= frameCnt + 1'b1;
          if (blinkCnt == BLINK_LAST) begin
            blinkCnt <= '0;
            blink    <= ~blink;
          end else begin
            blinkCnt <= blinkCnt + 1'b1;
          end
        end
      end else begin
        blink <= 1'b0;
      end
    end
  end

  assign screen_state = state;

endmodule
